timer_irq_ctrl: RTL



---
 rtl/timer_irq_ctrl_pkg.sv | 17 +
 rtl/timer_irq_ctrl_if.sv | 20 ++
 rtl/irq_prio_enc.sv | 24 ++
 rtl/timer_irq_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/timer_irq_ctrl_pkg.sv
// Shared constants for the interrupt aggregator: register map, widths, vector layout.
package timer_irq_ctrl_pkg;

  localparam int unsigned IRQ_MAX       = 16;
  localparam int unsigned REG_W         = 16;
  localparam int unsigned ADDR_W        = 3;
  localparam int unsigned IDX_W         = 4;
  localparam int unsigned VEC_VALID_BIT = 15;

  localparam logic [ADDR_W-1:0] IRQ_PENDING  = 3'd0;
  localparam logic [ADDR_W-1:0] IRQ_MASK     = 3'd1;
  localparam logic [ADDR_W-1:0] IRQ_EDGE_SEL = 3'd2;
  localparam logic [ADDR_W-1:0] IRQ_ACTIVE   = 3'd3;
  localparam logic [ADDR_W-1:0] IRQ_VECTOR   = 3'd4;
  localparam logic [ADDR_W-1:0] IRQ_FORCE    = 3'd5;

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// Avalon-MM slave signals of the interrupt aggregator.
interface timer_irq_ctrl_if;
  import timer_irq_ctrl_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [REG_W-1:0]  writedata;
  logic [REG_W-1:0]  readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder with valid flag.
module irq_prio_enc
  import timer_irq_ctrl_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Interrupt aggregator: per-source level/edge capture, mask, force, combined irq and vector.
module timer_irq_ctrl
  import timer_irq_ctrl_pkg::*;
#(
  parameter int unsigned N_IRQ = 8
) (
  input  logic                clk,
  input  logic                reset,
  timer_irq_ctrl_if.slave     bus,
  input  logic [N_IRQ-1:0]    irq_in,
  output logic                irq
);

  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] edge_sel_q, edge_sel_d;
  logic [N_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [REG_W-1:0] vector_q, vector_d;
  logic [REG_W-1:0] readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic [N_IRQ-1:0] active;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_valid;

  assign active = pending_q & mask_q;

  irq_prio_enc #(.N(N_IRQ)) u_prio_enc (
    .req   (active),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // Register writes, capture logic, vector and read mux.
  always_comb begin
    logic             wr_en;
    logic [N_IRQ-1:0] wdata;
    logic [N_IRQ-1:0] w1c;
    logic [N_IRQ-1:0] force_set;

    wr_en     = bus.chipselect & ~bus.write_n;
    wdata     = bus.writedata[N_IRQ-1:0];
    w1c       = (wr_en && bus.address == IRQ_PENDING) ? wdata : '0;
    force_set = (wr_en && bus.address == IRQ_FORCE)   ? wdata : '0;

    mask_d     = (wr_en && bus.address == IRQ_MASK)     ? wdata : mask_q;
    edge_sel_d = (wr_en && bus.address == IRQ_EDGE_SEL) ? wdata : edge_sel_q;
    irq_prev_d = irq_in;

    // Edge sources latch until W1C (set beats clear); level sources follow the input.
    pending_d = '0;
    for (int i = 0; i < int'(N_IRQ); i++) begin
      if (edge_sel_q[i]) begin
        pending_d[i] = (pending_q[i] & ~w1c[i]) | (irq_in[i] & ~irq_prev_q[i]) | force_set[i];
      end else begin
        pending_d[i] = irq_in[i] | force_set[i];
      end
    end

    irq_d    = |active;
    vector_d = '0;
    if (enc_valid) begin
      vector_d[VEC_VALID_BIT] = 1'b1;
      vector_d[IDX_W-1:0]     = enc_idx;
    end

    // Read data is loaded every cycle whatever chipselect says.
    readdata_d = '0;
    case (bus.address)
      IRQ_PENDING:  readdata_d = REG_W'(pending_q);
      IRQ_MASK:     readdata_d = REG_W'(mask_q);
      IRQ_EDGE_SEL: readdata_d = REG_W'(edge_sel_q);
      IRQ_ACTIVE:   readdata_d = REG_W'(active);
      IRQ_VECTOR:   readdata_d = vector_q;
      default:      readdata_d = '0;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      mask_q     <= '0;
      edge_sel_q <= '0;
      irq_prev_q <= '0;
      vector_q   <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      edge_sel_q <= edge_sel_d;
      irq_prev_q <= irq_prev_d;
      vector_q   <= vector_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule
